// File: rtl/qtr_pkg.sv
// qtr_pkg: shared state encoding and default constants for the QTR RC sensor reader
package qtr_pkg;
  typedef enum logic [1:0] {IDLE, CHARGE, MEASURE, DONE} state_t;
  localparam int N_CH_D = 8;
  localparam int CHARGE_CYC_D = 500;
  localparam int TIMEOUT_D = 150000;
  localparam int CNT_W_D = 18;
endpackage

// File: rtl/qtr_sync.sv
// qtr_sync: parameterized-width 2-FF synchronizer, flops preset to 1 on reset
module qtr_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= '1;
    else {q, m} <= {m, d};
endmodule

// File: rtl/qtr_rc_reader.sv
// qtr_rc_reader: charges QTR RC sensor lines, then times each line's discharge
module qtr_rc_reader
  import qtr_pkg::*;
#(
  parameter int N_CH = N_CH_D,
  parameter int CHARGE_CYC = CHARGE_CYC_D,
  parameter int TIMEOUT = TIMEOUT_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_CH-1:0]       sen_in,
  output logic                  sen_oe,
  output logic                  led_on,
  output logic                  busy,
  output logic                  done,
  output logic [N_CH*CNT_W-1:0] cnt_flat,
  output logic [N_CH-1:0]       to_flags
);
  localparam int CC_W = $clog2(CHARGE_CYC + 1);
  state_t st;
  logic [N_CH-1:0] s, lat, lat_n;
  logic [CC_W-1:0] cc;
  logic [CNT_W-1:0] t;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_n [N_CH];
  logic fin;
  qtr_sync #(.W(N_CH)) u_sync (.clk(clk), .rst(rst), .d(sen_in), .q(s));
  always_comb begin
    lat_n = lat | ~s;
    for (int i = 0; i < N_CH; i++) cnt_n[i] = (!lat[i] && !s[i]) ? t : cnt_q[i];
    fin = &lat_n || t == CNT_W'(TIMEOUT - 1);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      {sen_oe, led_on, busy, done} <= '0;
      cc <= '0;
      t <= '0;
      lat <= '0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      cnt_flat <= '0;
      to_flags <= '0;
    end else
      case (st)
        IDLE:
          if (start) begin
            st <= CHARGE;
            {sen_oe, led_on, busy} <= 3'b111;
            cc <= '0;
            lat <= '0;
          end
        CHARGE:
          if (cc == CC_W'(CHARGE_CYC - 1)) begin
            st <= MEASURE;
            sen_oe <= 1'b0;
            t <= '0;
          end else cc <= cc + 1'b1;
        MEASURE: begin
          lat <= lat_n;
          cnt_q <= cnt_n;
          t <= t + 1'b1;
          // outputs only move here, so they stay stable across the next run
          if (fin) begin
            st <= DONE;
            {led_on, busy, done} <= 3'b001;
            for (int i = 0; i < N_CH; i++)
              cnt_flat[i*CNT_W +: CNT_W] <= lat_n[i] ? cnt_n[i] : CNT_W'(TIMEOUT);
            to_flags <= ~lat_n;
          end
        end
        default: begin
          st <= IDLE;
          done <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_qtr_rc_reader.sv
// tb_qtr_rc_reader: directed checks of charge/measure timing, counts, timeouts and reset
module tb_qtr_rc_reader;
  localparam int N = 8, CC = 4, TO = 20, W = 18;
  logic clk = 0, rst = 1, start = 0;
  logic [N-1:0] sen_in = '1;
  logic sen_oe, led_on, busy, done;
  logic [N*W-1:0] cnt_flat;
  logic [N-1:0] to_flags;
  int checks = 0, failures = 0;
  qtr_rc_reader #(.N_CH(N), .CHARGE_CYC(CC), .TIMEOUT(TO), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sen_in(sen_in), .sen_oe(sen_oe),
    .led_on(led_on), .busy(busy), .done(done), .cnt_flat(cnt_flat), .to_flags(to_flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // ft[i] = MEASURE cycle t at which synchronized line i first reads low
  task automatic drive(input int ft[N], input int j);
    for (int i = 0; i < N; i++) sen_in[i] = !(ft[i] <= j - 2);
  endtask
  task automatic measure(input string tag, input int ft[N], input bit spam, input int exp_lat);
    int j, lat, oe_cyc, ec;
    logic stable;
    logic [N*W-1:0] prev;
    prev = cnt_flat;
    stable = 1;
    oe_cyc = 0;
    lat = -1;
    j = 0;
    @(negedge clk);
    start = 1;
    drive(ft, -1);
    while (lat < 0 && j < 60) begin
      @(posedge clk);
      #1;
      if (sen_oe) oe_cyc++;
      if (done) lat = j + 1;
      else if (cnt_flat !== prev) stable = 0;
      @(negedge clk);
      start = spam && (j == 2 || j == 6);
      drive(ft, j);
      j++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_oe_cycles"}, oe_cyc, CC);
    chk({tag, "_stable"}, stable, 1);
    for (int i = 0; i < N; i++) begin
      ec = ft[i] < 0 ? 0 : ft[i] > TO - 1 ? TO : ft[i];
      chk($sformatf("%s_cnt%0d", tag, i), cnt_flat[i*W +: W], ec);
      chk($sformatf("%s_flag%0d", tag, i), to_flags[i], ft[i] > TO - 1);
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
  endtask
  initial begin
    int f[N];
    int nd;
    #12;
    chk("rst_oe", sen_oe, 0);
    chk("rst_led", led_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", |cnt_flat, 0);
    chk("rst_flags", to_flags, 0);
    @(negedge clk);
    rst = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < N; i++) f[i] = 2 * i + 1;
    measure("stagger", f, 0, 21);
    for (int i = 0; i < N; i++) f[i] = 100;
    measure("all_high", f, 0, 25);
    for (int i = 0; i < N; i++) f[i] = -100;
    measure("all_low", f, 0, 6);
    for (int i = 0; i < N; i++) f[i] = 2 * i + 1;
    measure("restart", f, 1, 21);
    for (int i = 0; i < N; i++) f[i] = 3;
    measure("after_done", f, 0, 9);
    @(negedge clk);
    start = 1;
    sen_in = '1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1;
    #1;
    chk("arst_oe", sen_oe, 0);
    chk("arst_led", led_on, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cnt", |cnt_flat, 0);
    chk("arst_flags", to_flags, 0);
    @(negedge clk);
    rst = 0;
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("arst_no_done", nd, 0);
    for (int i = 0; i < N; i++) f[i] = 2 * i + 1;
    measure("post_rst", f, 0, 21);
    for (int i = 0; i < N; i++) f[i] = i == 0 ? TO - 1 : 100;
    measure("edge_t19", f, 0, 25);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
